// File: rtl/music_pkg.sv
// ============================================================================
// Module   : music_pkg
// Purpose  : Shared types and widths for the song player: frequency/duration
//            widths, the playback state encoding and the ROM word layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package music_pkg;

    localparam int FREQ_W  = 11;
    localparam int DUR_W   = 8;
    localparam int c_rom_w = 2 * FREQ_W + DUR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // One note: both voice frequency codes and its length in ticks.
    // dur == 0 terminates the song; a zero frequency rests that voice.
    typedef struct packed {
        logic [FREQ_W-1:0] freq1;
        logic [FREQ_W-1:0] freq2;
        logic [DUR_W-1:0]  dur;
    } rom_word_t;

endpackage

`default_nettype wire

// File: rtl/song_player_if.sv
// ============================================================================
// Module   : song_player_if
// Purpose  : Control and status bundle between a controller and the song
//            player. master = controller side, slave = player side.
//            start/stop/loop : playback control towards the player
//            c_freq1/c_freq2 : computer voice frequency codes (0 = silence)
//            playing/done    : status; done is a one-cycle end-of-song pulse
//            note_idx        : ROM index of the note currently handled
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface song_player_if #(
    parameter int ADDR_W = 6
);
    import music_pkg::*;

    logic              start;
    logic              stop;
    logic              loop;
    logic [FREQ_W-1:0] c_freq1;
    logic [FREQ_W-1:0] c_freq2;
    logic              playing;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    modport master (
        output start, stop, loop,
        input  c_freq1, c_freq2, playing, done, note_idx
    );

    modport slave (
        input  start, stop, loop,
        output c_freq1, c_freq2, playing, done, note_idx
    );

endinterface

`default_nettype wire

// File: rtl/song_rom.sv
// ============================================================================
// Module   : song_rom
// Purpose  : Note ROM, SONG_LEN x 30 bits, synchronous read with one cycle of
//            latency. Contents are fixed at elaboration from SONG_INIT, the
//            packed image of song.mem (entry i in bits [i*30 +: 30]).
//            Clk    : read clock
//            i_addr : note index
//            o_data : note word for the address presented one cycle earlier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_rom
    import music_pkg::*;
#(
    parameter int                          SONG_LEN  = 64,
    parameter int                          ADDR_W    = 6,
    parameter logic [SONG_LEN*c_rom_w-1:0] SONG_INIT = '0
) (
    input  wire logic              Clk,
    input  wire logic [ADDR_W-1:0] i_addr,
    output rom_word_t              o_data
);

    localparam int c_depth = 2 ** ADDR_W;

    rom_word_t w_mem [c_depth];
    rom_word_t r_data;

    // Addresses past the end of the song read as a terminator (dur = 0).
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
        if (gi < SONG_LEN) begin : g_used
            assign w_mem[gi] = SONG_INIT[gi*c_rom_w +: c_rom_w];
        end else begin : g_unused
            assign w_mem[gi] = '0;
        end
    end

    always_ff @(posedge Clk) begin
        r_data <= w_mem[i_addr];
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/song_player.sv
// ============================================================================
// Module   : song_player
// Purpose  : Plays a two-voice song from a note ROM. Each note is fetched,
//            loaded, held for dur ticks, then followed by GAP_TICKS silent
//            ticks. The frequency codes drive the computer-side inputs of the
//            human/computer frequency selector unchanged.
//            Clk   : system clock, rising edge
//            Reset : synchronous, active-low
//            sp    : song_player_if slave (start/stop/loop in;
//                    c_freq1/c_freq2/playing/done/note_idx out, all registered)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_player
    import music_pkg::*;
#(
    parameter int                          TICK_DIV  = 50000,
    parameter int                          SONG_LEN  = 64,
    parameter int                          ADDR_W    = 6,
    parameter int                          GAP_TICKS = 2,
    parameter logic [SONG_LEN*c_rom_w-1:0] SONG_INIT = '0
) (
    input wire logic     Clk,
    input wire logic     Reset,
    song_player_if.slave sp
);

    localparam int                 c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]   c_last_idx  = ADDR_W'(SONG_LEN - 1);
    localparam logic [DUR_W-1:0]    c_gap_ticks = DUR_W'(GAP_TICKS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_tick_w-1:0] w_tick_cnt_nxt;
    logic [DUR_W-1:0]    r_remaining;
    logic [DUR_W-1:0]    w_remaining_nxt;
    logic [FREQ_W-1:0]   r_freq1;
    logic [FREQ_W-1:0]   r_freq2;
    logic [FREQ_W-1:0]   w_freq1_nxt;
    logic [FREQ_W-1:0]   w_freq2_nxt;
    logic [ADDR_W-1:0]   r_note_idx;
    logic [ADDR_W-1:0]   w_note_idx_nxt;
    logic                r_playing;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_tick;
    logic                w_advance;
    logic                w_end_song;
    rom_word_t           w_rom_q;

    // The ROM address is the registered index, so the word read during FETCH
    // is available in LOAD.
    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .ADDR_W    (ADDR_W),
        .SONG_INIT (SONG_INIT)
    ) u_rom (
        .Clk    (Clk),
        .i_addr (r_note_idx),
        .o_data (w_rom_q)
    );

    assign w_tick = ((r_state == S_PLAY) || (r_state == S_GAP)) && (r_tick_cnt == c_tick_last);

    always_comb begin
        w_state_nxt     = r_state;
        w_freq1_nxt     = r_freq1;
        w_freq2_nxt     = r_freq2;
        w_note_idx_nxt  = r_note_idx;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_advance       = 1'b0;
        w_end_song      = 1'b0;
        w_tick_cnt_nxt  = '0;

        case (r_state)
            S_IDLE: begin
                w_freq1_nxt     = '0;
                w_freq2_nxt     = '0;
                w_note_idx_nxt  = '0;
                w_remaining_nxt = '0;
                if (sp.start && !sp.stop) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_rom_q.dur == '0) begin
                    w_end_song = 1'b1;
                end else begin
                    w_freq1_nxt     = w_rom_q.freq1;
                    w_freq2_nxt     = w_rom_q.freq2;
                    w_remaining_nxt = w_rom_q.dur;
                    w_state_nxt     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_tick) begin
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == DUR_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            // The remaining counter is reused to time the gap.
                            w_remaining_nxt = c_gap_ticks;
                            w_freq1_nxt     = '0;
                            w_freq2_nxt     = '0;
                            w_state_nxt     = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == DUR_W'(1)) begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_advance) begin
            w_freq1_nxt = '0;
            w_freq2_nxt = '0;
            if (r_note_idx == c_last_idx) begin
                w_end_song = 1'b1;
            end else begin
                w_note_idx_nxt = r_note_idx + 1'b1;
                w_state_nxt    = S_FETCH;
            end
        end

        if (w_end_song) begin
            w_freq1_nxt     = '0;
            w_freq2_nxt     = '0;
            w_note_idx_nxt  = '0;
            w_remaining_nxt = '0;
            if (sp.loop) begin
                w_state_nxt = S_FETCH;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end

        // Abort wins over everything decided above.
        if (sp.stop && (r_state != S_IDLE)) begin
            w_state_nxt     = S_IDLE;
            w_freq1_nxt     = '0;
            w_freq2_nxt     = '0;
            w_note_idx_nxt  = '0;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b0;
        end

        // Tick divider runs only while staying in PLAY or GAP; any state change
        // (including PLAY -> GAP) restarts it from zero.
        if (((w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP)) &&
            (w_state_nxt == r_state) && !w_tick) begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_remaining <= '0;
            r_freq1     <= '0;
            r_freq2     <= '0;
            r_note_idx  <= '0;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_remaining <= w_remaining_nxt;
            r_freq1     <= w_freq1_nxt;
            r_freq2     <= w_freq2_nxt;
            r_note_idx  <= w_note_idx_nxt;
            r_playing   <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign sp.c_freq1  = r_freq1;
    assign sp.c_freq2  = r_freq2;
    assign sp.playing  = r_playing;
    assign sp.done     = r_done;
    assign sp.note_idx = r_note_idx;

endmodule

`default_nettype wire

// File: tb/tb_song_player.sv
// ============================================================================
// Module   : tb_song_player
// Purpose  : Self-checking bench for song_player. Two players share one clock
//            and reset: player A holds {440,0,3},{523,659,2},{0,0,0}, player B
//            holds four {100,200,1} notes with no terminator. Expected
//            per-cycle outputs come from expanding each song into segments
//            (fetch, load, note, gap) with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_player;
    import music_pkg::*;

    localparam int TD  = 4;
    localparam int GT  = 1;
    localparam int LEN = 4;
    localparam int AW  = 2;

    localparam logic [LEN*30-1:0] ROM_A = {30'd0, 30'd0,
                                           {11'd523, 11'd659, 8'd2},
                                           {11'd440, 11'd0,   8'd3}};
    localparam logic [LEN*30-1:0] ROM_B = {4{11'd100, 11'd200, 8'd1}};

    localparam int SF1  [2][LEN] = '{'{440, 523, 0, 0}, '{100, 100, 100, 100}};
    localparam int SF2  [2][LEN] = '{'{0,   659, 0, 0}, '{200, 200, 200, 200}};
    localparam int SDUR [2][LEN] = '{'{3,   2,   0, 0}, '{1,   1,   1,   1}};

    typedef struct packed {
        logic [10:0]   f1;
        logic [10:0]   f2;
        logic          pl;
        logic          dn;
        logic [AW-1:0] idx;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    obs_t exp_q [$];
    obs_t hist  [0:63];

    always #5 clk = ~clk;

    song_player_if #(.ADDR_W(AW)) if_a ();
    song_player_if #(.ADDR_W(AW)) if_b ();

    song_player #(.TICK_DIV(TD), .SONG_LEN(LEN), .ADDR_W(AW), .GAP_TICKS(GT), .SONG_INIT(ROM_A))
        dut_a (.Clk(clk), .Reset(rst_n), .sp(if_a));
    song_player #(.TICK_DIV(TD), .SONG_LEN(LEN), .ADDR_W(AW), .GAP_TICKS(GT), .SONG_INIT(ROM_B))
        dut_b (.Clk(clk), .Reset(rst_n), .sp(if_b));

    function automatic obs_t mk(input int f1, input int f2, input bit pl, input bit dn, input int idx);
        obs_t o;
        o.f1  = f1[10:0];
        o.f2  = f2[10:0];
        o.pl  = pl;
        o.dn  = dn;
        o.idx = idx[AW-1:0];
        return o;
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.f1 = if_a.c_freq1; o.f2 = if_a.c_freq2; o.pl = if_a.playing;
            o.dn = if_a.done;    o.idx = if_a.note_idx;
        end else begin
            o.f1 = if_b.c_freq1; o.f2 = if_b.c_freq2; o.pl = if_b.playing;
            o.dn = if_b.done;    o.idx = if_b.note_idx;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input bit st, input bit sp, input bit lp);
        if (sel == 0) begin
            if_a.start = st; if_a.stop = sp; if_a.loop = lp;
        end else begin
            if_b.start = st; if_b.stop = sp; if_b.loop = lp;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed f1=%0d f2=%0d playing=%0b done=%0b idx=%0d expected f1=%0d f2=%0d playing=%0b done=%0b idx=%0d",
                   tag, got.f1, got.f2, got.pl, got.dn, got.idx, want.f1, want.f2, want.pl, want.dn, want.idx);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Expected outputs for cycles 0..n, where start is sampled at the end of
    // cycle 0 and stop (if stop_at > 0) is sampled at the end of cycle stop_at.
    task automatic build(input int sel, input bit lp, input int stop_at, input int n);
        int   idx;
        obs_t idle_o;
        idle_o = mk(0, 0, 0, 0, 0);
        exp_q.delete();
        exp_q.push_back(idle_o);
        idx = 0;
        while (exp_q.size() <= n) begin
            repeat (2) exp_q.push_back(mk(0, 0, 1, 0, idx));
            if (SDUR[sel][idx] != 0) begin
                repeat (SDUR[sel][idx] * TD) exp_q.push_back(mk(SF1[sel][idx], SF2[sel][idx], 1, 0, idx));
                repeat (GT * TD) exp_q.push_back(mk(0, 0, 1, 0, idx));
            end
            if ((SDUR[sel][idx] == 0) || (idx == LEN - 1)) begin
                idx = 0;
                if (!lp) begin
                    exp_q.push_back(mk(0, 0, 0, 1, 0));
                    while (exp_q.size() <= n) exp_q.push_back(idle_o);
                end
            end else begin
                idx++;
            end
        end
        if (stop_at > 0) begin
            for (int k = stop_at + 1; k < exp_q.size(); k++) exp_q[k] = idle_o;
        end
    endtask

    task automatic run_song(input string name, input int sel, input bit lp, input int stop_at,
                            input int extra_start, input int n);
        obs_t got;
        int   xs;
        build(sel, lp, stop_at, n);
        xs = extra_start;
        if ((xs > 0) && (xs <= n) && !exp_q[xs].pl) xs = 0;
        drive(sel, 1'b1, 1'b0, lp);
        tick();
        for (int k = 1; k <= n; k++) begin
            got     = sample(sel);
            hist[k] = got;
            check($sformatf("%s_c%0d", name, k), got, exp_q[k]);
            drive(sel, (k == xs), (k == stop_at), lp);
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cleanup(input string name);
        drive(0, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        check({name, "_idle_a"}, sample(0), mk(0, 0, 0, 0, 0));
        check({name, "_idle_b"}, sample(1), mk(0, 0, 0, 0, 0));
    endtask

    initial begin
        int s;
        int cnt;
        bit lp;
        int sel;
        int stop_at;

        // Reset held low with start asserted: both players stay idle.
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            check("reset_a", sample(0), mk(0, 0, 0, 0, 0));
            check("reset_b", sample(1), mk(0, 0, 0, 0, 0));
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_reset_a", sample(0), mk(0, 0, 0, 0, 0));

        // Natural end of song.
        run_song("song", 0, 1'b0, 0, 0, 40);
        check_val("song_f1_c3",   int'(hist[3].f1),  440);
        check_val("song_f1_c14",  int'(hist[14].f1), 440);
        check_val("song_f1_c15",  int'(hist[15].f1), 0);
        check_val("song_f2_c21",  int'(hist[21].f2), 659);
        check_val("song_f1_c28",  int'(hist[28].f1), 523);
        check_val("song_f1_c29",  int'(hist[29].f1), 0);
        check_val("song_done_c34", int'(hist[34].dn), 0);
        check_val("song_done_c35", int'(hist[35].dn), 1);
        check_val("song_play_c35", int'(hist[35].pl), 0);
        cleanup("song");

        // Looping: 440 returns at cycle 37 and done never pulses.
        run_song("loop", 0, 1'b1, 45, 0, 48);
        check_val("loop_f1_c37", int'(hist[37].f1), 440);
        cnt = 0;
        for (int k = 1; k <= 48; k++) cnt += int'(hist[k].dn);
        check_val("loop_no_done", cnt, 0);
        cleanup("loop");

        // Stop during the second note, then a fresh start from index 0.
        s = $urandom_range(21, 28);
        run_song("stop", 0, 1'b0, s, 0, 40);
        check_val("stop_play_after", int'(hist[s+1].pl), 0);
        check_val("stop_f2_after",   int'(hist[s+1].f2), 0);
        run_song("restart", 0, 1'b0, 0, 0, 6);
        check_val("restart_f1_c3",  int'(hist[3].f1), 440);
        check_val("restart_idx_c3", int'(hist[3].idx), 0);
        cleanup("restart");

        // Full ROM without terminator: ends after the last index's gap.
        run_song("full", 1, 1'b0, 0, 0, 45);
        check_val("full_idx_c40",  int'(hist[40].idx), LEN - 1);
        check_val("full_done_c41", int'(hist[41].dn), 1);
        check_val("full_idx_c41",  int'(hist[41].idx), 0);
        cleanup("full");

        // Reset during PLAY with start and stop high, then start+stop in IDLE.
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("rst_mid_play", sample(0), mk(440, 0, 1, 0, 0));
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0);
        tick();
        check("rst_mid_idle", sample(0), mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("start_stop_idle", sample(0), mk(0, 0, 0, 0, 0));
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        tick();

        // Randomized runs: song choice, loop, stop point, ignored mid-play start.
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 1));
            lp  = 1'($urandom_range(0, 1));
            if (lp) stop_at = int'($urandom_range(2, 44));
            else    stop_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 44)) : 0;
            repeat ($urandom_range(0, 3)) tick();
            run_song($sformatf("rnd%0d", it), sel, lp, stop_at, int'($urandom_range(1, 44)), 46);
            cleanup($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clocks per duration tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter SONG_LEN, default 64: ROM depth in notes.
REQ-003 SHALL have parameter ADDR_W, default 6: note index width; SONG_LEN <= 2**ADDR_W.
REQ-004 SHALL have parameter GAP_TICKS, default 2: silent ticks between notes.
REQ-005 SHALL have port Clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port Reset, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port start, input, 1: begin playback from index 0; sampled once per cycle.
REQ-008 SHALL have port stop, input, 1: abort playback.
REQ-009 SHALL have port loop, input, 1: at end of song, restart instead of finishing.
REQ-010 SHALL have port c_freq1, output, 11: computer voice 1 frequency code; 0 = silence.
REQ-011 SHALL have port c_freq2, output, 11: computer voice 2 frequency code; 0 = silence.
REQ-012 SHALL have port playing, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on natural song end.
REQ-014 SHALL have port note_idx, output, ADDR_W: index of the current ROM entry.

Function
REQ-015 ROM word SHALL be {freq1[10:0], freq2[10:0], dur[7:0]}.
- dur = note length in ticks.
- dur = 0 marks end of song.
- freq = 0 is a rest for that voice.
REQ-016 States SHALL be IDLE, FETCH, LOAD, PLAY, GAP.
REQ-017 IDLE: outputs 0 and note_idx = 0; start -> FETCH.
REQ-018 FETCH SHALL present note_idx to the synchronous ROM and go to LOAD after 1 cycle.
REQ-019 LOAD:
- dur = 0 -> end-of-song.
- Otherwise latch freq1/freq2 into c_freq1/c_freq2, set remaining = dur, go to PLAY.
REQ-020 PLAY:
- Hold latched frequencies.
- Decrement remaining on each tick.
- After the tick that makes remaining 0: go to GAP, or straight to advance if GAP_TICKS = 0.
REQ-021 GAP: c_freq1 = c_freq2 = 0 for exactly GAP_TICKS ticks, then advance.
REQ-022 Advance:
- note_idx = SONG_LEN-1 -> end-of-song.
- Otherwise note_idx + 1, go to FETCH.
REQ-023 End-of-song:
- loop = 1 -> note_idx = 0, FETCH, no done pulse.
- loop = 0 -> done high for 1 cycle, go to IDLE.
REQ-024 Tick divider:
- Counts 0..TICK_DIV-1 only in PLAY and GAP.
- Cleared on entry to each of those states.
- Tick pulse on the cycle where the count equals TICK_DIV-1.
- Resulting durations: PLAY lasts exactly dur*TICK_DIV cycles; GAP lasts exactly GAP_TICKS*TICK_DIV cycles.
REQ-025 Latency: c_freq outputs SHALL show the first note 3 cycles after the cycle in which start is sampled (FETCH, LOAD, then PLAY).
REQ-026 Start-to-start spacing of consecutive notes SHALL be 2 + (dur + GAP_TICKS)*TICK_DIV cycles.
REQ-027 stop in any non-IDLE state SHALL force IDLE on the next edge, with outputs 0 and no done pulse.
REQ-028 stop SHALL take priority over start in the same cycle.
REQ-029 start while playing SHALL be ignored.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 When Reset is low at a rising edge, the block SHALL enter IDLE with:
- c_freq1 = 0, c_freq2 = 0
- playing = 0, done = 0, note_idx = 0
- tick counter = 0, remaining = 0
REQ-032 Reset SHALL override start and stop, and SHALL abort playback in any state mid-operation.

Structure
REQ-033 Package music_pkg SHALL hold:
- FREQ_W = 11
- DUR_W = 8
- the state enum
- the ROM word packed struct
REQ-034 Sub-module song_rom SHALL provide the note ROM:
- synchronous read, 1-cycle latency, SONG_LEN x 30 bits
- contents loaded from song.mem at elaboration
REQ-035 c_freq1/c_freq2 SHALL feed the computer-side inputs of the human/computer frequency selector unchanged.

Verification
All scenarios use TICK_DIV = 4 and GAP_TICKS = 1.
REQ-036 Reset held low 3 cycles, start high -> all outputs 0, state IDLE.
REQ-037 ROM {440,0,3},{523,659,2},{0,0,0}; start pulse at cycle 0 -> expected response:
- c_freq1 = 440, c_freq2 = 0 for cycles 3..14
- 0/0 for cycles 15..18
- 523/659 for cycles 21..28
- 0/0 for cycles 29..32
- done pulse at cycle 35, then IDLE
REQ-038 Same ROM with loop = 1 -> 440 reappears at cycle 37; no done pulse.
REQ-039 stop during the 523/659 note -> next cycle outputs 0, playing = 0, no done pulse; a later start restarts at note_idx 0 with 440.
REQ-040 ROM filled with SONG_LEN entries {100,200,1}, no terminator -> after the index SONG_LEN-1 gap, done pulses and note_idx returns to 0.
REQ-041 Reset low during PLAY with start and stop both high -> next edge IDLE, all outputs 0; start and stop both high in IDLE -> remains IDLE.
